// File: rtl/mem_access_stage.sv
// MEM-stage controller: req/ack data-memory handshake, store lane alignment,
// load extension, pipeline stall generation and the MEM/WB pipeline register.
module mem_access_stage #(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] result,
  input  logic [31:0] write_data,
  input  logic [4:0]  RegDest,
  input  logic [3:0]  control_signals_M,
  input  logic [1:0]  control_signals_WB,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic [31:0] dmem_addr,
  output logic [31:0] dmem_wdata,
  output logic [3:0]  dmem_be,
  input  logic        dmem_ack,
  input  logic [31:0] dmem_rdata,
  output logic        stall,
  output logic        mem_err,
  output logic [4:0]  RegDestOut,
  output logic [1:0]  control_signals_WB_out,
  output logic [31:0] result_out,
  output logic [31:0] read_data_out
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  logic [0:0]  state;
  logic [31:0] cnt;
  logic [31:0] res_q;
  logic [4:0]  rd_q;
  logic [1:0]  wb_q;
  logic [1:0]  size_q;
  logic [1:0]  off_q;

  logic        mem_read, mem_write, mem_op, misaligned, aligned_op, timeout_hit;
  logic [1:0]  size, off;
  logic [3:0]  be_next;
  logic [31:0] wdata_next, load_ext;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;

  always_comb begin
    mem_read    = control_signals_M[0];
    mem_write   = control_signals_M[1];
    size        = control_signals_M[3:2];
    off         = result[1:0];
    mem_op      = mem_read | mem_write;
    misaligned  = ((size == 2'b00) && (off != 2'b00)) || ((size == 2'b01) && off[0]);
    aligned_op  = mem_op & ~misaligned;
    timeout_hit = (state == BUSY) && !dmem_ack && (TIMEOUT != 0) && (cnt == TIMEOUT - 1);
    // Low in the ack cycle so EX/MEM advances on the same edge MEM/WB captures the load
    stall       = ((state == IDLE) && aligned_op) ||
                  ((state == BUSY) && !dmem_ack && !timeout_hit);

    case (size)
      2'b00: begin
        be_next    = 4'b1111;
        wdata_next = write_data;
      end
      2'b01: begin
        be_next    = off[1] ? 4'b1100 : 4'b0011;
        wdata_next = {2{write_data[15:0]}};
      end
      default: begin
        be_next    = 4'b0001 << off;
        wdata_next = {4{write_data[7:0]}};
      end
    endcase

    half_sel = off_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
    byte_sel = dmem_rdata[{off_q, 3'b000} +: 8];
    case (size_q)
      2'b00:   load_ext = dmem_rdata;
      2'b01:   load_ext = {{16{half_sel[15]}}, half_sel};
      2'b10:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      default: load_ext = {24'b0, byte_sel};
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state                  <= IDLE;
      cnt                    <= '0;
      dmem_req               <= 1'b0;
      dmem_we                <= 1'b0;
      dmem_addr              <= '0;
      dmem_wdata             <= '0;
      dmem_be                <= '0;
      mem_err                <= 1'b0;
      res_q                  <= '0;
      rd_q                   <= '0;
      wb_q                   <= '0;
      size_q                 <= '0;
      off_q                  <= '0;
      RegDestOut             <= '0;
      control_signals_WB_out <= '0;
      result_out             <= '0;
      read_data_out          <= '0;
    end else begin
      // MEM/WB defaults to a bubble; only completed ops and non-mem ops override
      mem_err                <= 1'b0;
      RegDestOut             <= '0;
      control_signals_WB_out <= '0;
      result_out             <= '0;
      read_data_out          <= '0;
      case (state)
        IDLE: begin
          if (aligned_op) begin
            state      <= BUSY;
            cnt        <= '0;
            dmem_req   <= 1'b1;
            dmem_we    <= mem_write;
            dmem_addr  <= {result[31:2], 2'b00};
            dmem_be    <= be_next;
            dmem_wdata <= wdata_next;
            res_q      <= result;
            rd_q       <= RegDest;
            wb_q       <= control_signals_WB;
            size_q     <= size;
            off_q      <= off;
          end else if (mem_op) begin
            mem_err <= 1'b1;
          end else begin
            RegDestOut             <= RegDest;
            control_signals_WB_out <= control_signals_WB;
            result_out             <= result;
          end
        end
        default: begin
          if (dmem_ack) begin
            state                  <= IDLE;
            cnt                    <= '0;
            dmem_req               <= 1'b0;
            RegDestOut             <= rd_q;
            control_signals_WB_out <= wb_q;
            result_out             <= res_q;
            read_data_out          <= dmem_we ? '0 : load_ext;
          end else if (timeout_hit) begin
            state    <= IDLE;
            cnt      <= '0;
            dmem_req <= 1'b0;
            mem_err  <= 1'b1;
          end else begin
            cnt <= cnt + 32'd1;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_stage.sv
// Randomized and directed checks of mem_access_stage against a behavioural model.
module tb_mem_access_stage;

  localparam int TO = 4;

  logic        clk;
  logic        rst;
  logic [31:0] result;
  logic [31:0] write_data;
  logic [4:0]  RegDest;
  logic [3:0]  control_signals_M;
  logic [1:0]  control_signals_WB;
  logic        dmem_req;
  logic        dmem_we;
  logic [31:0] dmem_addr;
  logic [31:0] dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ack;
  logic [31:0] dmem_rdata;
  logic        stall;
  logic        mem_err;
  logic [4:0]  RegDestOut;
  logic [1:0]  control_signals_WB_out;
  logic [31:0] result_out;
  logic [31:0] read_data_out;

  int ncmp = 0;
  int nfail = 0;

  mem_access_stage #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .result(result), .write_data(write_data),
    .RegDest(RegDest), .control_signals_M(control_signals_M),
    .control_signals_WB(control_signals_WB), .dmem_req(dmem_req),
    .dmem_we(dmem_we), .dmem_addr(dmem_addr), .dmem_wdata(dmem_wdata),
    .dmem_be(dmem_be), .dmem_ack(dmem_ack), .dmem_rdata(dmem_rdata),
    .stall(stall), .mem_err(mem_err), .RegDestOut(RegDestOut),
    .control_signals_WB_out(control_signals_WB_out), .result_out(result_out),
    .read_data_out(read_data_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    ncmp++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [3:0] exp_be(input logic [1:0] sz, input logic [1:0] off);
    if (sz == 2'd0) return 4'hF;
    if (sz == 2'd1) return (off >= 2) ? 4'hC : 4'h3;
    return 4'(1 << off);
  endfunction

  function automatic logic [31:0] exp_wdata(input logic [1:0] sz, input logic [31:0] wd);
    if (sz == 2'd0) return wd;
    if (sz == 2'd1) return (wd & 32'hFFFF) * 32'h0001_0001;
    return (wd & 32'hFF) * 32'h0101_0101;
  endfunction

  function automatic logic [31:0] exp_ext(input logic [31:0] r, input logic [1:0] sz,
                                          input logic [1:0] off);
    logic [31:0] v;
    case (sz)
      2'd0: return r;
      2'd1: begin
        v = (r >> (16 * (off / 2))) & 32'hFFFF;
        return (v >= 32'h8000) ? (v | 32'hFFFF_0000) : v;
      end
      2'd2: begin
        v = (r >> (8 * off)) & 32'hFF;
        return (v >= 32'h80) ? (v | 32'hFFFF_FF00) : v;
      end
      default: return (r >> (8 * off)) & 32'hFF;
    endcase
  endfunction

  // ack_at: BUSY cycle (1-based) in which ack arrives; 0 = never
  task automatic run_op(input logic [31:0] res, input logic [31:0] wd, input logic [4:0] rd,
                        input logic [3:0] m, input logic [1:0] wb, input int ack_at,
                        input logic [31:0] rdata);
    logic [1:0] sz, off;
    bit wr, mem, mis, done;
    int stalls, reqs, exp_cyc;
    sz   = m[3:2];
    off  = res[1:0];
    wr   = m[1];
    mem  = m[0] | m[1];
    mis  = ((sz == 2'd0) && (off != 0)) || ((sz == 2'd1) && off[0]);
    result = res; write_data = wd; RegDest = rd;
    control_signals_M = m; control_signals_WB = wb;
    dmem_ack = 1'b0; dmem_rdata = $urandom;
    #1;
    if (!mem) begin
      check("nop_stall", stall, 0);
      @(posedge clk); #1;
      check("nop_result", result_out, res);
      check("nop_rd", RegDestOut, rd);
      check("nop_wb", control_signals_WB_out, wb);
      check("nop_rdata", read_data_out, 0);
      check("nop_err", mem_err, 0);
      check("nop_req", dmem_req, 0);
    end else if (mis) begin
      check("mis_stall", stall, 0);
      @(posedge clk); #1;
      check("mis_err", mem_err, 1);
      check("mis_req", dmem_req, 0);
      check("mis_wb", control_signals_WB_out, 0);
      check("mis_rd", RegDestOut, 0);
      check("mis_result", result_out, 0);
    end else begin
      check("issue_stall", stall, 1);
      stalls = 1; reqs = 0; done = 0;
      exp_cyc = (ack_at >= 1 && ack_at <= TO) ? ack_at : TO;
      @(posedge clk); #1;
      for (int k = 1; k <= 20 && !done; k++) begin
        check("busy_req", dmem_req, 1);
        check("busy_we", dmem_we, wr);
        check("busy_addr", dmem_addr, res & 32'hFFFF_FFFC);
        check("busy_be", dmem_be, exp_be(sz, off));
        check("busy_wdata", dmem_wdata, exp_wdata(sz, wd));
        check("busy_bubble", control_signals_WB_out, 0);
        check("busy_err", mem_err, 0);
        reqs++;
        // EX/MEM contents must not matter once the op is latched
        result = $urandom; write_data = $urandom; RegDest = 5'($urandom);
        control_signals_M = 4'($urandom); control_signals_WB = 2'($urandom);
        if (ack_at == k) begin
          dmem_ack = 1'b1; dmem_rdata = rdata;
          #1;
          check("ack_stall", stall, 0);
          @(posedge clk); #1;
          dmem_ack = 1'b0; dmem_rdata = $urandom;
          check("done_req", dmem_req, 0);
          check("done_result", result_out, res);
          check("done_rd", RegDestOut, rd);
          check("done_wb", control_signals_WB_out, wb);
          check("done_rdata", read_data_out, wr ? 32'h0 : exp_ext(rdata, sz, off));
          check("done_err", mem_err, 0);
          done = 1;
        end else if (k == TO) begin
          dmem_rdata = $urandom;
          #1;
          check("to_stall", stall, 0);
          @(posedge clk); #1;
          check("to_req", dmem_req, 0);
          check("to_err", mem_err, 1);
          check("to_wb", control_signals_WB_out, 0);
          check("to_rd", RegDestOut, 0);
          done = 1;
        end else begin
          dmem_rdata = $urandom;
          #1;
          check("wait_stall", stall, 1);
          stalls++;
          @(posedge clk); #1;
        end
      end
      check("busy_bound", done, 1);
      check("stall_cycles", stalls, exp_cyc);
      check("req_cycles", reqs, exp_cyc);
    end
  endtask

  initial begin
    rst = 1'b0;
    result = '0; write_data = '0; RegDest = '0;
    control_signals_M = '0; control_signals_WB = '0;
    dmem_ack = 1'b0; dmem_rdata = '0;
    @(posedge clk); @(posedge clk); #1;
    check("rst_req", dmem_req, 0);
    check("rst_we", dmem_we, 0);
    check("rst_addr", dmem_addr, 0);
    check("rst_be", dmem_be, 0);
    check("rst_err", mem_err, 0);
    check("rst_wb", control_signals_WB_out, 0);
    check("rst_result", result_out, 0);
    check("rst_rdata", read_data_out, 0);
    check("rst_stall", stall, 0);
    rst = 1'b1;

    run_op(32'h1234, 32'h0, 5'd5, 4'b0000, 2'b01, 0, 32'h0);
    run_op(32'h100, 32'h0, 5'd9, 4'b0001, 2'b11, 3, 32'hDEAD_BEEF);
    run_op(32'h103, 32'h0, 5'd3, 4'b1001, 2'b11, 1, 32'h80FF_0000);
    run_op(32'h103, 32'h0, 5'd3, 4'b1101, 2'b11, 2, 32'h80FF_0000);
    run_op(32'h102, 32'h0, 5'd4, 4'b0101, 2'b11, 1, 32'h80FF_0000);
    run_op(32'h201, 32'h1234_56AB, 5'd0, 4'b1010, 2'b00, 2, 32'h0);
    run_op(32'h102, 32'h0, 5'd6, 4'b0001, 2'b11, 1, 32'h0);
    run_op(32'h44, 32'h0, 5'd7, 4'b0000, 2'b01, 0, 32'h0);
    run_op(32'h400, 32'h0, 5'd8, 4'b0001, 2'b11, 0, 32'h0);
    run_op(32'h48, 32'h0, 5'd2, 4'b0000, 2'b01, 0, 32'h0);

    // asynchronous reset in the middle of an outstanding access
    result = 32'h300; RegDest = 5'd10; control_signals_M = 4'b0001;
    control_signals_WB = 2'b11;
    @(posedge clk); #1;
    check("pre_rst_req", dmem_req, 1);
    #2 rst = 1'b0;
    #1;
    check("arst_req", dmem_req, 0);
    check("arst_we", dmem_we, 0);
    check("arst_addr", dmem_addr, 0);
    check("arst_wdata", dmem_wdata, 0);
    check("arst_be", dmem_be, 0);
    check("arst_err", mem_err, 0);
    check("arst_rd", RegDestOut, 0);
    check("arst_wb", control_signals_WB_out, 0);
    check("arst_result", result_out, 0);
    check("arst_rdata", read_data_out, 0);
    result = '0; RegDest = '0; control_signals_M = '0; control_signals_WB = '0;
    #1;
    check("arst_stall", stall, 0);
    @(posedge clk); #1;
    rst = 1'b1;
    result = 32'h55; RegDest = 5'd7; control_signals_WB = 2'b01;
    dmem_ack = 1'b1; dmem_rdata = 32'hCAFE_F00D;
    @(posedge clk); #1;
    dmem_ack = 1'b0;
    check("late_ack_req", dmem_req, 0);
    check("late_ack_result", result_out, 32'h55);
    check("late_ack_rdata", read_data_out, 0);
    check("late_ack_wb", control_signals_WB_out, 2'b01);
    check("late_ack_err", mem_err, 0);
    run_op(32'h500, 32'h0, 5'd11, 4'b0001, 2'b11, 2, 32'h1357_9BDF);

    for (int i = 0; i < 60; i++) begin
      logic [3:0] m;
      if ($urandom_range(0, 3) == 0) m = {2'($urandom), 2'b00};
      else m = {2'($urandom), 2'($urandom_range(1, 3))};
      run_op($urandom, $urandom, 5'($urandom), m, 2'($urandom),
             int'($urandom_range(0, 6)), $urandom);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
Name: mem_access_stage

Overview:
- MEM-stage controller; consumes EX/MEM pipeline register outputs (address/result, store data, dest reg, M and WB control).
- Runs req/ack handshake to the data memory, aligns store data and byte enables, and sign/zero-extends load data.
- Stalls the pipeline while an access is outstanding; owns the MEM/WB pipeline register.

Parameters:
- TIMEOUT, 255, max cycles waiting for dmem_ack before abort; 0 disables timeout.

Ports:
- clk  input  1  clock, all state on posedge
- rst  input  1  asynchronous, active-low reset
- result  input  32  ALU result; memory byte address for loads/stores
- write_data  input  32  store data (EX op2)
- RegDest  input  5  destination register
- control_signals_M  input  4  [0] MemRead, [1] MemWrite, [3:2] size: 00 word, 01 half signed, 10 byte signed, 11 byte unsigned
- control_signals_WB  input  2  [0] RegWrite, [1] MemToReg
- dmem_req  output  1  request valid, registered
- dmem_we  output  1  1 = store
- dmem_addr  output  32  word-aligned address ({result[31:2],2'b00})
- dmem_wdata  output  32  lane-aligned store data
- dmem_be  output  4  byte enables
- dmem_ack  input  1  one-cycle completion pulse
- dmem_rdata  input  32  load word, valid with dmem_ack
- stall  output  1  freeze PC/IF-ID/ID-EX/EX-MEM, combinational
- mem_err  output  1  one-cycle pulse: misaligned access or timeout
- RegDestOut  output  5  MEM/WB dest register
- control_signals_WB_out  output  2  MEM/WB WB controls
- result_out  output  32  MEM/WB ALU result passthrough
- read_data_out  output  32  MEM/WB extended load data

Behaviour:
- Reset (rst low, async): state IDLE, dmem_req 0, dmem_we 0, dmem_addr/dmem_wdata 0, dmem_be 0, mem_err 0, timeout counter 0, all MEM/WB outputs 0. Outstanding access is abandoned; dmem_req drops immediately.
- mem_op = MemRead | MemWrite. If both are set, the access is a store and the read is ignored.
- Misaligned: word with result[1:0] != 0, or half with result[0] = 1.
- FSM state IDLE:
  - no mem_op: MEM/WB loads inputs next edge; read_data_out = 0.
  - aligned mem_op: latch addr, we, be, wdata, RegDest, WB ctrl, size, byte offset; dmem_req = 1 next edge; go BUSY; MEM/WB loads a bubble (all zeros).
  - misaligned mem_op: no request; mem_err = 1 next edge; MEM/WB loads a bubble; stay IDLE.
- FSM state BUSY: dmem_req held high with stable addr/we/be/wdata.
  - dmem_ack: dmem_req = 0 next edge; MEM/WB loads the latched op; go IDLE.
  - no ack, counter reaches TIMEOUT: dmem_req = 0; mem_err pulse; MEM/WB loads a bubble; go IDLE.
  - otherwise: counter increments; counter clears on leaving BUSY.
- stall = (IDLE & aligned mem_op) | (BUSY & ~dmem_ack & ~timeout_hit). Stall is low in the ack cycle so EX/MEM advances in the same edge. Stall is never asserted for misaligned ops or non-mem ops.
- Latency: 1-cycle ack gives a 2-cycle stall-free path impossible; minimum load/store costs 1 stall cycle plus memory wait cycles.
- Store lanes:
  - word: be 1111, wdata as-is.
  - half: be 0011 (off 0) / 1100 (off 2), wdata = {2{wd[15:0]}}.
  - byte: be = 0001 << off, wdata = {4{wd[7:0]}}.
- Load extraction uses the latched offset:
  - half: rdata[16*off[1]+:16], sign-extended.
  - byte: rdata[8*off+:8], sign-extended for size 10, zero-extended for size 11.
  - word: rdata as-is.
- For stores, read_data_out = 0 and WB ctrl passes through unchanged (decoder guarantees RegWrite = 0).
- dmem_ack while IDLE: ignored.

Test Plan:
- ALU op (M = 0000, WB = 01, result 0x1234, RegDest 5) -> next edge result_out 0x1234, RegDestOut 5, WB_out 01, stall never high.
- Load word at 0x100, ack after 3 cycles with rdata 0xDEADBEEF:
  - stall high for 3 cycles, req high for 3 cycles.
  - read_data_out 0xDEADBEEF, WB_out 11.
  - bubble (WB_out 00) during the wait.
- Byte loads at 0x103, rdata 0x80FF_0000:
  - size 10 -> read_data_out 0xFFFFFF80.
  - size 11 -> 0x00000080.
  - half signed at 0x102 -> 0xFFFF80FF.
- Store byte 0xAB at 0x201 (write_data 0x123456AB) -> dmem_be 0010, dmem_wdata 0xABABABAB, dmem_addr 0x200, dmem_we 1.
- Load word at 0x102 -> no dmem_req, mem_err one-cycle pulse, stall 0, WB_out 00. Then TIMEOUT = 4 with ack never arriving -> req drops after 4 BUSY cycles, mem_err pulse, stall releases.
- rst low while BUSY -> dmem_req 0 and all outputs 0 without a clock edge; a later ack is ignored; first op after reset proceeds normally.
